mem_align_unit: RTL and testbench

//  Load/store alignment unit between the EX and WB stages. It is the sequential

---
 rtl/mem_pkg.sv | 44 ++++
 rtl/lane_align.sv | 71 +++++++
 rtl/mem_align_unit.sv | 150 +++++++++++++++
 tb/tb_mem_align_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-op encodings and decode helpers for the load/store alignment unit.
package mem_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_LWL = 4'd5,
        OP_LWR = 4'd6,
        OP_SB  = 4'd7,
        OP_SH  = 4'd8,
        OP_SW  = 4'd9,
        OP_SWL = 4'd10,
        OP_SWR = 4'd11
    } mem_op_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic is_store(mem_op_t op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
    endfunction

    function automatic logic is_unaligned_op(mem_op_t op);
        return op inside {OP_LWL, OP_LWR, OP_SWL, OP_SWR};
    endfunction

    function automatic logic [1:0] op_size(mem_op_t op);
        if (op inside {OP_LB, OP_LBU, OP_SB}) return SIZE_BYTE;
        if (op inside {OP_LH, OP_LHU, OP_SH}) return SIZE_HALF;
        return SIZE_WORD;
    endfunction

    // LWL/LWR/SWL/SWR are never misaligned; they are aligned down on the bus instead.
    function automatic logic addr_err(mem_op_t op, logic [1:0] lo);
        if (op inside {OP_LH, OP_LHU, OP_SH}) return lo[0];
        if (op inside {OP_LW, OP_SW}) return |lo;
        return 1'b0;
    endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational lane steering: load extend/merge and store strobe/data placement.
module lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  mem_op_t                       op,
    input  logic [$clog2(DATA_W/8)-1:0]   b,
    input  logic [DATA_W-1:0]             rt,
    input  logic [DATA_W-1:0]             rdata,
    output logic [DATA_W-1:0]             load_data,
    output logic [DATA_W/8-1:0]           wstrb,
    output logic [DATA_W-1:0]             wdata
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] ones;
    logic [DATA_W-1:0] rd_sh;
    logic [NB-1:0]     strb_all;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       word_v;
    int unsigned       sh_lo;
    int unsigned       sh_hi;

    always_comb begin
        ones      = '1;
        strb_all  = '1;
        sh_lo     = 8 * 32'(b);
        sh_hi     = 8 * (NB - 1 - 32'(b));
        rd_sh     = rdata >> sh_lo;
        byte_v    = rd_sh[7:0];
        half_v    = rd_sh[15:0];
        word_v    = rd_sh[31:0];
        load_data = '0;
        wstrb     = '0;
        wdata     = '0;
        case (op)
            OP_LB:  load_data = DATA_W'($signed(byte_v));
            OP_LBU: load_data = DATA_W'(byte_v);
            OP_LH:  load_data = DATA_W'($signed(half_v));
            OP_LHU: load_data = DATA_W'(half_v);
            OP_LW:  load_data = DATA_W'($signed(word_v));
            // Merges keep the rt bytes the partial load does not cover.
            OP_LWL: load_data = (rdata << sh_hi) | (rt & ~(ones << (DATA_W - sh_lo - 8)));
            OP_LWR: load_data = (rdata >> sh_lo) | (rt & ~(ones >> sh_lo));
            OP_SB: begin
                wdata = {NB{rt[7:0]}};
                wstrb = (strb_all >> (NB - 1)) << b;
            end
            OP_SH: begin
                wdata = {(NB/2){rt[15:0]}};
                wstrb = (strb_all >> (NB - 2)) << b;
            end
            OP_SW: begin
                wdata = {(NB/4){rt[31:0]}};
                wstrb = (strb_all >> (NB - 4)) << b;
            end
            OP_SWL: begin
                wdata = rt >> sh_hi;
                wstrb = strb_all >> (NB - 1 - 32'(b));
            end
            OP_SWR: begin
                wdata = rt << sh_lo;
                wstrb = strb_all << b;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_align_unit.sv
// Load/store alignment unit: one outstanding SRAM-like bus transaction, flushable.
//  state  | meaning
//  IDLE   | ready for a new op
//  REQ    | data_req asserted, waiting for addr_ok
//  WAIT   | address accepted, waiting for data_ok
//  DONE   | result held on out_* until out_ready
module mem_align_unit
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_rt,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_W-1:0]     data_addr,
    output logic [DATA_W/8-1:0]   data_wstrb,
    output logic [DATA_W-1:0]     data_wdata,
    input  logic                  data_addr_ok,
    input  logic [DATA_W-1:0]     data_rdata,
    input  logic                  data_data_ok,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_rdata,
    output logic                  out_adel,
    output logic                  out_ades,
    output logic [ADDR_W-1:0]     out_badvaddr
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(NB - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    mem_op_t           op_q, in_op_t;
    logic [ADDR_W-1:0] addr_q, badv_q;
    logic [DATA_W-1:0] rt_q, rdata_q, load_data, wdata;
    logic [NB-1:0]     wstrb;
    logic              cancel_q, adel_q, ades_q;
    logic              accept, in_err, cancel, bus_done;

    assign in_op_t = mem_op_t'(in_op);
    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid & in_ready & ~flush;
    assign in_err   = addr_err(in_op_t, in_addr[1:0]);
    assign cancel   = cancel_q | flush;

    lane_align #(.DATA_W(DATA_W)) u_lane (
        .op       (op_q),
        .b        (addr_q[OFF_W-1:0]),
        .rt       (rt_q),
        .rdata    (data_rdata),
        .load_data(load_data),
        .wstrb    (wstrb),
        .wdata    (wdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        bus_done = 1'b0;
        case (state_q)
            S_IDLE: if (accept) state_d = in_err ? S_DONE : S_REQ;
            S_REQ: begin
                // A same-cycle data_ok completes the transfer without visiting WAIT.
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        bus_done = 1'b1;
                        state_d  = cancel ? S_IDLE : S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    bus_done = 1'b1;
                    state_d  = cancel ? S_IDLE : S_DONE;
                end
            end
            S_DONE: if (out_ready || flush) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q     <= OP_LB;
            addr_q   <= '0;
            rt_q     <= '0;
            cancel_q <= 1'b0;
            rdata_q  <= '0;
            adel_q   <= 1'b0;
            ades_q   <= 1'b0;
            badv_q   <= '0;
        end else begin
            if (accept) begin
                op_q     <= in_op_t;
                addr_q   <= in_addr;
                rt_q     <= in_rt;
                cancel_q <= 1'b0;
                rdata_q  <= '0;
                adel_q   <= in_err & ~is_store(in_op_t);
                ades_q   <= in_err & is_store(in_op_t);
                badv_q   <= in_err ? in_addr : '0;
            end
            if ((state_q == S_REQ || state_q == S_WAIT) && flush) cancel_q <= 1'b1;
            if (bus_done && !is_store(op_q)) rdata_q <= load_data;
        end
    end

    assign data_req = (state_q == S_REQ);

    always_comb begin
        data_wr    = 1'b0;
        data_size  = SIZE_BYTE;
        data_addr  = '0;
        data_wstrb = '0;
        data_wdata = '0;
        if (state_q == S_REQ) begin
            data_wr   = is_store(op_q);
            data_size = op_size(op_q);
            data_addr = is_unaligned_op(op_q) ? (addr_q & ADDR_MASK) : addr_q;
            if (is_store(op_q)) begin
                data_wstrb = wstrb;
                data_wdata = wdata;
            end
        end
    end

    assign out_valid    = (state_q == S_DONE);
    assign out_rdata    = rdata_q;
    assign out_adel     = adel_q;
    assign out_ades     = ades_q;
    assign out_badvaddr = badv_q;

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed self-checking bench for mem_align_unit at DATA_W = 32.
module tb_mem_align_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_op;
    logic [31:0] in_addr, in_rt, data_addr, data_wdata, data_rdata;
    logic [31:0] out_rdata, out_badvaddr;
    logic        data_req, data_wr, data_addr_ok, data_data_ok, out_adel, out_ades;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic        bus_auto, aok_m, dok_m;

    int n_cmp = 0;
    int n_bad = 0;

    logic        r_req, r_wr, r_valid, r_adel, r_ades, r_idle;
    logic [1:0]  r_size;
    logic [3:0]  r_wstrb;
    logic [31:0] r_addr, r_wdata, r_rdata, r_badv;
    int          r_lat;

    always #5 clk = ~clk;

    always_comb begin
        data_addr_ok = bus_auto ? data_req : aok_m;
        data_data_ok = bus_auto ? data_req : dok_m;
    end

    mem_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_addr(in_addr), .in_rt(in_rt),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_adel(out_adel), .out_ades(out_ades), .out_badvaddr(out_badvaddr)
    );

    // Drives one op on the auto-completing bus and records what the DUT did.
    task automatic run_op(input mem_op_t op, input logic [31:0] addr, rt, rd);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_addr = addr; in_rt = rt; data_rdata = rd;
        @(negedge clk);
        in_valid = 1'b0;
        r_req = data_req; r_wr = data_wr; r_size = data_size; r_addr = data_addr;
        r_wstrb = data_wstrb; r_wdata = data_wdata;
        r_lat = 1;
        if (!out_valid) begin @(negedge clk); r_lat = 2; end
        r_valid = out_valid; r_rdata = out_rdata; r_adel = out_adel;
        r_ades = out_ades; r_badv = out_badvaddr;
        @(negedge clk);
        r_idle = in_ready && !out_valid;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if ({out_valid, data_req, data_wr, out_adel, out_ades} !== 5'b0) begin n_bad++; $display("FAIL reset_flags got=%b exp=00000", {out_valid, data_req, data_wr, out_adel, out_ades}); end
        n_cmp++; if ({out_rdata, out_badvaddr, data_addr, data_wdata} !== 128'h0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", {out_rdata, out_badvaddr, data_addr, data_wdata}); end
        resetn = 1'b1;
    endtask

    task automatic test_load_merge;
        run_op(OP_LWL, 32'h1001, 32'hAABBCCDD, 32'h44332211);
        n_cmp++; if (r_addr !== 32'h1000 || r_size !== 2'd2 || r_req !== 1'b1 || r_wr !== 1'b0) begin n_bad++; $display("FAIL lwl_bus got=%h/%0d/%b/%b exp=00001000/2/1/0", r_addr, r_size, r_req, r_wr); end
        n_cmp++; if (r_rdata !== 32'h2211CCDD) begin n_bad++; $display("FAIL lwl_rdata got=%h exp=2211ccdd", r_rdata); end
        n_cmp++; if (r_lat !== 2 || r_valid !== 1'b1 || r_idle !== 1'b1) begin n_bad++; $display("FAIL lwl_latency got=%0d/%b/%b exp=2/1/1", r_lat, r_valid, r_idle); end
        run_op(OP_LWR, 32'h1001, 32'hAABBCCDD, 32'h44332211);
        n_cmp++; if (r_rdata !== 32'hAA443322 || r_addr !== 32'h1000) begin n_bad++; $display("FAIL lwr_rdata got=%h@%h exp=aa443322@00001000", r_rdata, r_addr); end
    endtask

    task automatic test_load_extend;
        run_op(OP_LH, 32'h1002, 32'h0, 32'h80001234);
        n_cmp++; if (r_rdata !== 32'hFFFF8000 || r_addr !== 32'h1002 || r_size !== 2'd1) begin n_bad++; $display("FAIL lh got=%h@%h/%0d exp=ffff8000@00001002/1", r_rdata, r_addr, r_size); end
        run_op(OP_LHU, 32'h1002, 32'h0, 32'h80001234);
        n_cmp++; if (r_rdata !== 32'h00008000) begin n_bad++; $display("FAIL lhu got=%h exp=00008000", r_rdata); end
        run_op(OP_LBU, 32'h1001, 32'h0, 32'h44339211);
        n_cmp++; if (r_rdata !== 32'h00000092 || r_size !== 2'd0) begin n_bad++; $display("FAIL lbu got=%h/%0d exp=00000092/0", r_rdata, r_size); end
    endtask

    task automatic test_store_lanes;
        run_op(OP_SWL, 32'h2002, 32'h11223344, 32'h0);
        n_cmp++; if (r_wstrb !== 4'b0111 || r_wdata[23:0] !== 24'h112233) begin n_bad++; $display("FAIL swl got=%b/%h exp=0111/112233", r_wstrb, r_wdata[23:0]); end
        n_cmp++; if (r_addr !== 32'h2000 || r_wr !== 1'b1 || r_rdata !== 32'h0) begin n_bad++; $display("FAIL swl_bus got=%h/%b/%h exp=00002000/1/0", r_addr, r_wr, r_rdata); end
        run_op(OP_SWR, 32'h2002, 32'h11223344, 32'h0);
        n_cmp++; if (r_wstrb !== 4'b1100 || r_wdata[31:16] !== 16'h3344) begin n_bad++; $display("FAIL swr got=%b/%h exp=1100/3344", r_wstrb, r_wdata[31:16]); end
        run_op(OP_SB, 32'h2001, 32'h000000A5, 32'h0);
        n_cmp++; if (r_wstrb !== 4'b0010 || r_wdata !== 32'hA5A5A5A5 || r_addr !== 32'h2001 || r_size !== 2'd0) begin n_bad++; $display("FAIL sb got=%b/%h/%h/%0d exp=0010/a5a5a5a5/00002001/0", r_wstrb, r_wdata, r_addr, r_size); end
    endtask

    task automatic test_addr_err;
        run_op(OP_LW, 32'h1002, 32'h0, 32'h12345678);
        n_cmp++; if (r_req !== 1'b0 || r_lat !== 1) begin n_bad++; $display("FAIL adel_noreq got=%b/%0d exp=0/1", r_req, r_lat); end
        n_cmp++; if (r_adel !== 1'b1 || r_ades !== 1'b0 || r_badv !== 32'h1002) begin n_bad++; $display("FAIL adel got=%b/%b/%h exp=1/0/00001002", r_adel, r_ades, r_badv); end
        run_op(OP_SH, 32'h3, 32'h0, 32'h0);
        n_cmp++; if (r_ades !== 1'b1 || r_adel !== 1'b0 || r_badv !== 32'h3 || r_req !== 1'b0) begin n_bad++; $display("FAIL ades got=%b/%b/%h/%b exp=1/0/00000003/0", r_ades, r_adel, r_badv, r_req); end
    endtask

    task automatic test_stall;
        bus_auto = 1'b0; aok_m = 1'b0; dok_m = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_LW; in_addr = 32'h40; in_rt = 32'h0; data_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_cmp++; if (data_req !== 1'b1 || data_addr !== 32'h40 || data_size !== 2'd2 || in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_req[%0d] got=%b/%h/%0d/%b exp=1/00000040/2/0", i, data_req, data_addr, data_size, in_ready); end
            if (i == 3) aok_m = 1'b1;
        end
        @(negedge clk);
        aok_m = 1'b0;
        n_cmp++; if (data_req !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_wait got=%b/%b/%b exp=0/0/0", data_req, in_ready, out_valid); end
        @(negedge clk);
        dok_m = 1'b1; data_rdata = 32'hCAFEF00D;
        @(negedge clk);
        dok_m = 1'b0; data_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_rdata !== 32'hCAFEF00D || in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_hold[%0d] got=%b/%h/%b exp=1/cafef00d/0", i, out_valid, out_rdata, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release got=%b/%b exp=0/1", out_valid, in_ready); end
        bus_auto = 1'b1;
    endtask

    task automatic test_flush_inflight;
        bus_auto = 1'b0; aok_m = 1'b0; dok_m = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_LBU; in_addr = 32'h51; data_rdata = 32'h0;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if (data_req !== 1'b1 || data_addr !== 32'h51) begin n_bad++; $display("FAIL flush_req_held got=%b/%h exp=1/00000051", data_req, data_addr); end
        @(negedge clk);
        n_cmp++; if (data_req !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_req_held2 got=%b/%b exp=1/0", data_req, in_ready); end
        aok_m = 1'b1;
        @(negedge clk);
        aok_m = 1'b0; dok_m = 1'b1;
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_wait got=%b/%b exp=0/0", in_ready, out_valid); end
        @(negedge clk);
        dok_m = 1'b0; bus_auto = 1'b1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_absorbed got=%b/%b exp=0/1", out_valid, in_ready); end
        in_valid = 1'b1; in_op = OP_LB; in_addr = 32'h1003; in_rt = 32'h0; data_rdata = 32'h80FF0000;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (data_req !== 1'b1 || data_addr !== 32'h1003) begin n_bad++; $display("FAIL flush_next_req got=%b/%h exp=1/00001003", data_req, data_addr); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_rdata !== 32'hFFFFFF80) begin n_bad++; $display("FAIL flush_next_result got=%b/%h exp=1/ffffff80", out_valid, out_rdata); end
        @(negedge clk);
    endtask

    task automatic test_flush_misc;
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_op = OP_LW; in_addr = 32'h10;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        n_cmp++; if (in_ready !== 1'b1 || data_req !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_blocks_accept got=%b/%b/%b exp=1/0/0", in_ready, data_req, out_valid); end
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = OP_LBU; in_addr = 32'h1000; data_rdata = 32'h11;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_rdata !== 32'h11) begin n_bad++; $display("FAIL done_before_flush got=%b/%h exp=1/00000011", out_valid, out_rdata); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_done got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid;
        bus_auto = 1'b0; aok_m = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_LW; in_addr = 32'h100;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (data_req !== 1'b1) begin n_bad++; $display("FAIL midrst_pre got=%b exp=1", data_req); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (data_req !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst got=%b/%b exp=0/1", data_req, in_ready); end
        @(negedge clk);
        resetn = 1'b1; bus_auto = 1'b1;
    endtask

    initial begin
        flush = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_addr = '0; in_rt = '0;
        data_rdata = '0; out_ready = 1'b1; bus_auto = 1'b1; aok_m = 1'b0; dok_m = 1'b0;
        test_reset;
        test_load_merge;
        test_load_extend;
        test_store_lanes;
        test_addr_err;
        test_stall;
        test_flush_inflight;
        test_flush_misc;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
